drap_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the DRAP core. It owns the program counter and drives the address of the DRAP instruction ROM, which captures its 7-bit byte address on `clk` and returns the 32-bit word one cycle later. Each fetched word is buffered, together with its PC, in a 2-entry output queue toward decode under a valid/ready handshake. The block also handles redirects (branch/jump) and fetch enable/halt.

---
 rtl/drap_fetch_ctrl.sv | 89 ++++++++
 tb/tb_drap_fetch_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/drap_fetch_ctrl.sv
// drap_fetch_ctrl: PC sequencer for the DRAP instruction ROM with a 2-entry {data, pc} queue toward decode
module drap_fetch_ctrl #(
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [1:0]        count_q, count_d, rem;
    logic [2:0]        occ;
    logic              pop, push, issue;

    assign rom_addr   = pc_q;
    assign inst_valid = (count_q != 2'd0);
    assign inst_data  = head_data_q;
    assign inst_pc    = head_pc_q;

    // Issue credit, PC sequencing and queue update; a redirect overrides everything else
    always_comb begin
        pop           = inst_valid & inst_ready;
        push          = inflight_q & ~redirect_valid;
        occ           = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        issue         = ((state_q == RUN) | fetch_en) & fetch_en & ~redirect_valid & (occ < 3'd2);
        state_d       = fetch_en ? RUN : IDLE;
        pc_d          = redirect_valid ? (redirect_pc & ALIGN_MASK) : issue ? pc_q + PC_STEP : pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        rem           = count_q - 2'(pop);
        head_data_d   = (pop && count_q == 2'd2) ? tail_data_q : head_data_q;
        head_pc_d     = (pop && count_q == 2'd2) ? tail_pc_q : head_pc_q;
        tail_data_d   = tail_data_q;
        tail_pc_d     = tail_pc_q;
        if (push && rem == 2'd0) begin
            head_data_d = rom_data;
            head_pc_d   = inflight_pc_q;
        end
        if (push && rem == 2'd1) begin
            tail_data_d = rom_data;
            tail_pc_d   = inflight_pc_q;
        end
        count_d = redirect_valid ? 2'd0 : rem + 2'(push);
    end

    // State registers; reset drops every queued and in-flight word at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_data_q   <= '0;
            head_pc_q     <= '0;
            tail_data_q   <= '0;
            tail_pc_q     <= '0;
            count_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_data_q   <= head_data_d;
            head_pc_q     <= head_pc_d;
            tail_data_q   <= tail_data_d;
            tail_pc_q     <= tail_pc_d;
            count_q       <= count_d;
        end
    end
endmodule

// File: tb/tb_drap_fetch_ctrl.sv
// tb_drap_fetch_ctrl: scoreboard bench for the DRAP fetch sequencer
module tb_drap_fetch_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        fetch_en = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
    logic [6:0]  redirect_pc = '0;
    logic [6:0]  rom_addr, inst_pc;
    logic [31:0] rom_data = '0, inst_data;
    logic        inst_valid;
    logic [31:0] mem [32];
    int          total = 0, bad = 0;

    typedef struct {logic [6:0] pc; logic [31:0] data;} exp_t;
    exp_t q[$];
    exp_t e_m;

    drap_fetch_ctrl #(.ADDR_W(7), .DATA_W(32), .RESET_PC(7'h00)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    // ROM: registers the address at the edge, word available the following cycle
    always @(posedge clk) rom_data <= mem[rom_addr[6:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [6:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = mem[pc[6:2]];
        q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) step();
        chk("drain_left", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    // Monitor: every accepted word must match the head of the expectation queue
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got pc %h data %h want none", inst_pc, inst_data);
            end else begin
                e_m = q.pop_front();
                chk("mon_pc", 32'(inst_pc), 32'(e_m.pc));
                chk("mon_data", inst_data, e_m.data);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h02734820;
        mem[1] = 32'h02734820;
        mem[2] = 32'h02364820;
        mem[3] = 32'h8d280000;
        #12;
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", 32'(inst_pc), 32'h0);
        step();
        rst_n = 1'b1;
        // Streaming fetch with decode always ready
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        expect_pc(7'h00); expect_pc(7'h04); expect_pc(7'h08); expect_pc(7'h0C);
        step();
        chk("lat_e0_valid", 32'(inst_valid), 32'h0);
        chk("issue_e0_addr", 32'(rom_addr), 32'h4);
        step();
        chk("lat_e1_valid", 32'(inst_valid), 32'h1);
        chk("first_pc", 32'(inst_pc), 32'h0);
        repeat (4) step();
        chk("thru_q_empty", 32'(q.size()), 32'd0);
        inst_ready = 1'b0;
        // Restart at 0 and stall decode
        redirect_valid = 1'b1;
        redirect_pc    = 7'h00;
        step();
        redirect_valid = 1'b0;
        chk("stall_redir_valid", 32'(inst_valid), 32'h0);
        step();
        step();
        chk("stall_first_valid", 32'(inst_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_rom_addr", 32'(rom_addr), 32'h08);
            chk("stall_valid", 32'(inst_valid), 32'h1);
            chk("stall_head_pc", 32'(inst_pc), 32'h00);
            chk("stall_head_data", inst_data, 32'h02734820);
        end
        expect_pc(7'h00); expect_pc(7'h04); expect_pc(7'h08);
        inst_ready = 1'b1;
        step();
        chk("no_gap_valid", 32'(inst_valid), 32'h1);
        chk("no_gap_pc", 32'(inst_pc), 32'h04);
        drain();
        inst_ready = 1'b0;
        // Redirect to an unaligned target while words are queued and in flight
        chk("pre_redir_valid", 32'(inst_valid), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 7'h0B;
        step();
        redirect_valid = 1'b0;
        chk("redir_v0", 32'(inst_valid), 32'h0);
        expect_pc(7'h08); expect_pc(7'h0C); expect_pc(7'h10);
        expect_pc(7'h14); expect_pc(7'h18); expect_pc(7'h1C);
        inst_ready = 1'b1;
        step();
        chk("redir_v1", 32'(inst_valid), 32'h0);
        step();
        chk("redir_v2", 32'(inst_valid), 32'h1);
        chk("redir_pc", 32'(inst_pc), 32'h08);
        chk("redir_data", inst_data, 32'h02364820);
        step();
        step();
        // Halt fetching for three cycles mid-stream
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_rom_addr", 32'(rom_addr), 32'h18);
        end
        fetch_en = 1'b1;
        drain();
        inst_ready = 1'b0;
        // PC wrap-around
        redirect_valid = 1'b1;
        redirect_pc    = 7'h7C;
        step();
        redirect_valid = 1'b0;
        expect_pc(7'h7C); expect_pc(7'h00); expect_pc(7'h04);
        inst_ready = 1'b1;
        drain();
        inst_ready = 1'b0;
        // Asynchronous reset mid-stream
        step();
        step();
        chk("pre_rst_valid", 32'(inst_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(inst_valid), 32'h0);
        chk("arst_data", inst_data, 32'h0);
        chk("arst_pc", 32'(inst_pc), 32'h0);
        chk("arst_rom_addr", 32'(rom_addr), 32'h0);
        step();
        rst_n = 1'b1;
        expect_pc(7'h00); expect_pc(7'h04); expect_pc(7'h08);
        inst_ready = 1'b1;
        drain();
        inst_ready = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
